// File: rtl/vga_sync.sv
// Raster timing generator for 640x480@60: free-running X/Y counters, registered
// sync/visible flags aligned with the counters, delayed copies, frame and game ticks.
module vga_sync #(
  parameter int unsigned PIXEL_DISPLAY_BIT = 9,
  parameter int unsigned PIPE_DELAY        = 1,
  parameter int unsigned FRAMES_PER_TICK   = 6,
  parameter int unsigned H_SYNC            = 96,
  parameter int unsigned H_BACK            = 48,
  parameter int unsigned H_ACTIVE          = 640,
  parameter int unsigned H_FRONT           = 16,
  parameter int unsigned V_SYNC            = 2,
  parameter int unsigned V_BACK            = 33,
  parameter int unsigned V_ACTIVE          = 480,
  parameter int unsigned V_FRONT           = 10
) (
  input  logic                       clock_25,
  input  logic                       reset,
  input  logic                       tick_en,
  output logic [PIXEL_DISPLAY_BIT:0] X,
  output logic [PIXEL_DISPLAY_BIT:0] Y,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_on,
  output logic                       hsync_d,
  output logic                       vsync_d,
  output logic                       video_on_d,
  output logic                       frame_tick,
  output logic                       game_tick
);

  localparam int unsigned W           = PIXEL_DISPLAY_BIT + 1;
  localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_VIS_START = H_SYNC + H_BACK;
  localparam int unsigned H_VIS_END   = H_VIS_START + H_ACTIVE - 1;
  localparam int unsigned V_VIS_START = V_SYNC + V_BACK;
  localparam int unsigned V_VIS_END   = V_VIS_START + V_ACTIVE - 1;

  typedef logic [W-1:0] cnt_t;
  typedef logic [PIPE_DELAY-1:0] pipe_t;

  cnt_t       x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, ft_q, ft_d;
  pipe_t      hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, vo_pipe_q, vo_pipe_d;
  logic [5:0] fcnt_q, fcnt_d;
  logic       x_last, y_last, fcnt_last;

  // Flags are decoded from the next-state counters so that, once registered,
  // they describe the X/Y visible in the same cycle.
  always_comb begin
    x_last    = (x_q == cnt_t'(H_TOTAL - 1));
    y_last    = (y_q == cnt_t'(V_TOTAL - 1));
    fcnt_last = (fcnt_q == 6'(FRAMES_PER_TICK - 1));

    x_d = x_last ? '0 : x_q + cnt_t'(1);
    y_d = y_q;
    if (x_last) begin
      y_d = y_last ? '0 : y_q + cnt_t'(1);
    end

    hs_d = (x_d >= cnt_t'(H_SYNC));
    vs_d = (y_d >= cnt_t'(V_SYNC));
    vo_d = (x_d >= cnt_t'(H_VIS_START)) && (x_d <= cnt_t'(H_VIS_END)) &&
           (y_d >= cnt_t'(V_VIS_START)) && (y_d <= cnt_t'(V_VIS_END));
    ft_d = (x_d == cnt_t'(H_TOTAL - 1)) && (y_d == cnt_t'(V_TOTAL - 1));

    hs_pipe_d = (hs_pipe_q << 1) | pipe_t'(hs_q);
    vs_pipe_d = (vs_pipe_q << 1) | pipe_t'(vs_q);
    vo_pipe_d = (vo_pipe_q << 1) | pipe_t'(vo_q);

    // tick_en only matters during the frame_tick cycle
    fcnt_d = fcnt_q;
    if (ft_q && tick_en) begin
      fcnt_d = fcnt_last ? '0 : fcnt_q + 6'd1;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      vo_q      <= 1'b0;
      ft_q      <= 1'b0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      vo_pipe_q <= '0;
      fcnt_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      vo_q      <= vo_d;
      ft_q      <= ft_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      vo_pipe_q <= vo_pipe_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign X          = x_q;
  assign Y          = y_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign video_on   = vo_q;
  assign hsync_d    = hs_pipe_q[PIPE_DELAY-1];
  assign vsync_d    = vs_pipe_q[PIPE_DELAY-1];
  assign video_on_d = vo_pipe_q[PIPE_DELAY-1];
  assign frame_tick = ft_q;
  assign game_tick  = ft_q & tick_en & fcnt_last;

endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing generator for the 640x480@60 Hz display, clocked by the 25 MHz pixel clock. Produces the raw horizontal and vertical counters `X`/`Y` that drive the background, snake and text-overlay stages. It also generates sync pulses, a visible-area flag and frame-rate and game-rate tick pulses. It provides delayed sync/visible outputs so the VGA connector sees them aligned with the one-cycle-registered pixel data from the downstream stages.

## Interface

Parameters:

- `PIXEL_DISPLAY_BIT`, 9: MSB index of `X`/`Y`; counters are `PIXEL_DISPLAY_BIT+1` bits.
- `PIPE_DELAY`, 1: cycles of delay applied to `hsync_d`, `vsync_d`, `video_on_d`. Legal range 1..4.
- `FRAMES_PER_TICK`, 6: frames per `game_tick` pulse. Legal range 1..63.

Ports:

- `clock_25`, in, 1: 25 MHz pixel clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick_en`, in, 1: enables the game-tick frame counter.
- `X`, out, 10: raw horizontal counter, 0..799.
- `Y`, out, 10: raw vertical counter, 0..524.
- `hsync`, out, 1: horizontal sync, active low, consistent with the current `X`.
- `vsync`, out, 1: vertical sync, active low, consistent with the current `Y`.
- `video_on`, out, 1: high when `X`/`Y` lie in the visible area.
- `hsync_d`, out, 1: `hsync` delayed `PIPE_DELAY` cycles.
- `vsync_d`, out, 1: `vsync` delayed `PIPE_DELAY` cycles.
- `video_on_d`, out, 1: `video_on` delayed `PIPE_DELAY` cycles.
- `frame_tick`, out, 1: one-cycle pulse on the last pixel of each frame.
- `game_tick`, out, 1: one-cycle pulse every `FRAMES_PER_TICK` enabled frames.

## Operation

Counters:
- `X` increments every cycle and wraps 799 -> 0.
- `Y` increments only when `X` wraps, and wraps 524 -> 0 when `X`=799 and `Y`=524.
- Counters include the sync and porch intervals; `X`/`Y` are not offset to the visible origin.

Horizontal timing:
- Sync: `X` 0..95, `hsync`=0.
- Back porch: 96..143.
- Visible: 144..783.
- Front porch: 784..799.

Vertical timing:
- Sync: `Y` 0..1, `vsync`=0.
- Back porch: 2..34.
- Visible: 35..514.
- Front porch: 515..524.

Sync and visible outputs:
- `hsync`, `vsync` and `video_on` are registered. Compute them from the next-state counter values so they describe the `X`/`Y` present in the same cycle.
- `video_on` = (144 <= X <= 783) and (35 <= Y <= 514).
- Delayed outputs come from a `PIPE_DELAY`-deep shift register per signal.

Frame tick:
- `frame_tick` is high exactly in the cycle where `X`=799 and `Y`=524.

Game tick:
- A 6-bit frame counter `fcnt` advances on `frame_tick` when `tick_en`=1.
- When `fcnt`=`FRAMES_PER_TICK-1`, `game_tick` pulses in the same cycle as `frame_tick`, and `fcnt` returns to 0.
- `tick_en`=0: `fcnt` holds and `game_tick`=0, even on `frame_tick`.
- `FRAMES_PER_TICK`=1: `game_tick` = `frame_tick` & `tick_en`.

## Timing

- Reset values (asserted asynchronously):
  - `X`=0, `Y`=0, `fcnt`=0.
  - `hsync`=0, `vsync`=0, `video_on`=0 (consistent with X=0, Y=0).
  - All delay-stage registers: `hsync_d`=1, `vsync_d`=1, `video_on_d`=0.
  - `frame_tick`=0, `game_tick`=0.
- First rising edge after reset release: `X`=1. Counting is free-running with no start handshake.
- Reset asserted mid-frame: all outputs take their reset values immediately; the count restarts from 0,0 after release.
- Line period is 800 cycles; frame period is 420000 cycles.
- After reset release, the first `frame_tick` occurs when the counters first reach X=799, Y=524, then every 420000 cycles.
- `tick_en` is sampled on the `frame_tick` cycle only.
- `tick_en` toggling mid-frame has no effect on `fcnt` until the next `frame_tick`.
- `hsync_d` first reflects the first real `hsync` value `PIPE_DELAY` cycles after reset release; until then it carries the reset value 1.
- Boundary at X=783 -> 784: `video_on` falls in the same cycle `X` becomes 784.
- Boundary at Y=514 -> 515: `video_on` remains 0 for the whole of lines 515..524.

## Test plan

- Reset and release, run 1000 cycles.
  - X reads 0..799, then 0 with Y=1.
  - `hsync` is 0 for exactly 96 cycles per line, starting at X=0.
- Run a full frame.
  - Y wraps 524 -> 0.
  - `vsync` is low for exactly 1600 cycles (2 lines).
  - `video_on` is high for exactly 307200 cycles.
- `PIPE_DELAY`=1.
  - `hsync_d` equals `hsync` from the previous cycle throughout.
  - `video_on_d` first rises at X=145, Y=35.
- `tick_en`=1, `FRAMES_PER_TICK`=6, run 13 frames.
  - `game_tick` pulses on the 6th and 12th `frame_tick` only.
  - Each pulse coincides with X=799, Y=524.
- `tick_en` dropped after 3 frames and raised again 2 frames later.
  - The next `game_tick` occurs on the 8th `frame_tick` after reset.
- Assert `reset` at X=400, Y=200.
  - All outputs reach their reset values without waiting for a clock edge.
  - After release, X=1, Y=0 on the first edge.
